crc_stream_engine: RTL and testbench

//  Parametrised CRC engine for the fake_n64 link layer; successor to the bit-serial CRC-8 generator.

---
 rtl/crc_pkg.sv | 49 ++++
 rtl/crc_chunk_fold.sv | 47 ++++
 rtl/crc_stream_engine.sv | 176 +++++++++++++++++
 tb/tb_crc_stream_engine.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_pkg
//  Description : Shared constants, FSM state encoding and the single-bit CRC
//                step used by the stream CRC engine and its chunk folder.
//                The link-layer CRC is CRC-8, polynomial 0x85, seed 0x00,
//                with no output XOR.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam logic [7:0] N64_CRC_POLY    = 8'h85;
    localparam logic [7:0] N64_CRC_SEED    = 8'h00;
    localparam logic [7:0] N64_CRC_XOR_OUT = 8'h00;

    // Widest CRC the engine supports; the step function always works at this
    // width and masks the result down to the active width.
    localparam int CRC_MAX_WIDTH = 32;

    typedef enum logic [0:0] {
        CRC_IDLE  = 1'b0,
        CRC_SHIFT = 1'b1
    } crc_state_e;

    // One message bit through the shift register. The data bit enters at the
    // LSB (non-augmented form); the bit shifted out of the active MSB decides
    // whether the taps are applied. Bits above 'width' must be zero on entry.
    function automatic logic [CRC_MAX_WIDTH-1:0] crc_bit_step(
        input logic [CRC_MAX_WIDTH-1:0] window,
        input logic [CRC_MAX_WIDTH-1:0] poly,
        input logic                     d,
        input int                       width
    );
        logic [CRC_MAX_WIDTH-1:0] shifted;
        logic [CRC_MAX_WIDTH-1:0] mask;
        shifted = {window[CRC_MAX_WIDTH-2:0], d};
        if (window[width-1]) begin
            shifted = shifted ^ poly;
        end
        if (width >= CRC_MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return shifted & mask;
    endfunction

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_chunk_fold.sv
`default_nettype none
// ============================================================================
//  Module      : crc_chunk_fold
//  Description : Combinational fold of one chunk (BITS_PER_CYCLE bits) of a
//                message byte into the CRC window. Chunk idx_i selects stream
//                bits idx_i*BITS_PER_CYCLE .. idx_i*BITS_PER_CYCLE+BPC-1, where
//                stream order is MSB-first unless LSB_FIRST is set.
//  Ports       : window_i  current CRC window
//                byte_i    latched message byte
//                idx_i     chunk index within the byte
//                window_o  window after folding the chunk
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_chunk_fold
    import crc_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] POLY           = N64_CRC_POLY,
    parameter int               BITS_PER_CYCLE = 1,
    parameter bit               LSB_FIRST      = 1'b0,
    parameter int               IDX_W          = 3
) (
    input  logic [WIDTH-1:0] window_i,
    input  logic [7:0]       byte_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] window_o
);

    logic [CRC_MAX_WIDTH-1:0] w_acc;
    logic [2:0]               w_pos;
    logic                     w_bit;

    always_comb begin
        w_acc = CRC_MAX_WIDTH'(window_i);
        w_pos = 3'd0;
        w_bit = 1'b0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            // Position of this bit in stream order within the byte.
            w_pos = 3'(int'(idx_i) * BITS_PER_CYCLE + j);
            w_bit = LSB_FIRST ? byte_i[w_pos] : byte_i[3'd7 - w_pos];
            w_acc = crc_bit_step(w_acc, CRC_MAX_WIDTH'(POLY), w_bit, WIDTH);
        end
        window_o = w_acc[WIDTH-1:0];
    end

endmodule : crc_chunk_fold
`default_nettype wire

// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module      : crc_stream_engine
//  Description : Byte-stream CRC generator/checker. Accepts bytes over a
//                valid/ready handshake, folds BITS_PER_CYCLE bits per clock
//                and, after the byte flagged last, emits the final CRC
//                (XOR_OUT applied) with a match flag against expect_crc.
//  Ports       : clk, reset_n            clock, async active-low reset
//                seed_load, seed_value   abort message, load new seed/reinit
//                in_valid/in_ready       byte handshake
//                in_data, in_last        message byte, end-of-message flag
//                expect_crc              reference CRC, taken with last byte
//                crc_valid               one-cycle result strobe
//                crc, crc_match          result, held until next strobe
//                busy                    engine is folding a byte
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] POLY           = N64_CRC_POLY,
    parameter logic [WIDTH-1:0] SEED           = N64_CRC_SEED,
    parameter logic [WIDTH-1:0] XOR_OUT        = N64_CRC_XOR_OUT,
    parameter int               BITS_PER_CYCLE = 1,
    parameter bit               LSB_FIRST      = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic [WIDTH-1:0] expect_crc,
    output logic             crc_valid,
    output logic [WIDTH-1:0] crc,
    output logic             crc_match,
    output logic             busy
);

    localparam int CHUNKS = 8 / BITS_PER_CYCLE;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

    crc_state_e       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [7:0]       byte_q,      byte_d;
    logic             last_q,      last_d;
    logic [WIDTH-1:0] exp_q,       exp_d;
    logic [WIDTH-1:0] window_q,    window_d;
    logic [WIDTH-1:0] reinit_q,    reinit_d;
    logic [WIDTH-1:0] crc_q,       crc_d;
    logic             match_q,     match_d;
    logic             crc_valid_q, crc_valid_d;

    logic             w_final;
    logic             w_ready;
    logic             w_hs;
    logic [WIDTH-1:0] w_fold;
    logic [WIDTH-1:0] w_crc_next;

    crc_chunk_fold #(
        .WIDTH          (WIDTH),
        .POLY           (POLY),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .LSB_FIRST      (LSB_FIRST),
        .IDX_W          (CNT_W)
    ) u_fold (
        .window_i (window_q),
        .byte_i   (byte_q),
        .idx_i    (cnt_q),
        .window_o (w_fold)
    );

    // Final chunk of the current byte is being folded this cycle.
    assign w_final    = (state_q == CRC_SHIFT) && (cnt_q == CNT_LAST);
    // A new byte may be taken while the last chunk of a non-final byte folds,
    // which keeps BITS_PER_CYCLE=8 bubble-free.
    assign w_ready    = !seed_load &&
                        ((state_q == CRC_IDLE) || (w_final && !last_q));
    assign w_hs       = in_valid && w_ready;
    assign w_crc_next = w_fold ^ XOR_OUT;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        last_d      = last_q;
        exp_d       = exp_q;
        window_d    = window_q;
        reinit_d    = reinit_q;
        crc_d       = crc_q;
        match_d     = match_q;
        crc_valid_d = 1'b0;

        if (seed_load) begin
            // Abort whatever is in flight; the result registers keep the
            // previous message's CRC.
            window_d = seed_value;
            reinit_d = seed_value;
            cnt_d    = '0;
            state_d  = CRC_IDLE;
        end else begin
            case (state_q)
                CRC_IDLE: begin
                    if (w_hs) begin
                        byte_d  = in_data;
                        last_d  = in_last;
                        exp_d   = expect_crc;
                        cnt_d   = '0;
                        state_d = CRC_SHIFT;
                    end
                end
                CRC_SHIFT: begin
                    window_d = w_fold;
                    if (!w_final) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (last_q) begin
                        crc_valid_d = 1'b1;
                        crc_d       = w_crc_next;
                        match_d     = (w_crc_next == exp_q);
                        window_d    = reinit_q;
                        state_d     = CRC_IDLE;
                    end else if (w_hs) begin
                        byte_d  = in_data;
                        last_d  = in_last;
                        exp_d   = expect_crc;
                        cnt_d   = '0;
                        state_d = CRC_SHIFT;
                    end else begin
                        state_d = CRC_IDLE;
                    end
                end
                default: begin
                    state_d = CRC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CRC_IDLE;
            cnt_q       <= '0;
            byte_q      <= '0;
            last_q      <= 1'b0;
            exp_q       <= '0;
            window_q    <= SEED;
            reinit_q    <= SEED;
            crc_q       <= '0;
            match_q     <= 1'b0;
            crc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            exp_q       <= exp_d;
            window_q    <= window_d;
            reinit_q    <= reinit_d;
            crc_q       <= crc_d;
            match_q     <= match_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign in_ready  = w_ready;
    assign crc_valid = crc_valid_q;
    assign crc       = crc_q;
    assign crc_match = match_q;
    assign busy      = (state_q == CRC_SHIFT);

endmodule : crc_stream_engine
`default_nettype wire

// File: tb/tb_crc_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_stream_engine
//  Description : Self-checking bench for crc_stream_engine. Five engines share
//                the data inputs: BITS_PER_CYCLE 1/2/4/8 MSB-first, and a
//                BITS_PER_CYCLE=2 LSB-first build. Expected CRCs come from a
//                bit-serial model and are queued on the last handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_stream_engine;

    localparam int NI = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            seed_load = 1'b0;
    logic [7:0]      seed_value = 8'h00;
    logic [NI-1:0]   in_valid_v = '0;
    logic [NI-1:0]   in_ready_v;
    logic [7:0]      in_data = 8'h00;
    logic            in_last = 1'b0;
    logic [7:0]      expect_crc = 8'h00;
    logic [NI-1:0]   crc_valid_v;
    logic [NI-1:0][7:0] crc_v;
    logic [NI-1:0]   match_v;
    logic [NI-1:0]   busy_v;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs_cyc = 0;
    int pulses [NI];

    logic [7:0] cur_seed = 8'h00;
    logic [7:0] mwin     = 8'h00;
    logic [7:0] sb_crc [$];
    bit         sb_match [$];

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            localparam int BPC_G = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 2;
            localparam bit LSB_G = (g == 4);
            crc_stream_engine #(
                .WIDTH          (8),
                .POLY           (8'h85),
                .SEED           (8'h00),
                .XOR_OUT        (8'h00),
                .BITS_PER_CYCLE (BPC_G),
                .LSB_FIRST      (LSB_G)
            ) u_dut (
                .clk        (clk),
                .reset_n    (reset_n),
                .seed_load  (seed_load),
                .seed_value (seed_value),
                .in_valid   (in_valid_v[g]),
                .in_ready   (in_ready_v[g]),
                .in_data    (in_data),
                .in_last    (in_last),
                .expect_crc (expect_crc),
                .crc_valid  (crc_valid_v[g]),
                .crc        (crc_v[g]),
                .crc_match  (match_v[g]),
                .busy       (busy_v[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial for (int b = 0; b < NI; b++) pulses[b] = 0;

    always @(negedge clk) begin
        for (int b = 0; b < NI; b++) begin
            if (crc_valid_v[b] === 1'b1) pulses[b] <= pulses[b] + 1;
        end
    end

    function automatic int bpc_of(input int b);
        return (b == 0) ? 1 : (b == 1) ? 2 : (b == 2) ? 4 : (b == 3) ? 8 : 2;
    endfunction

    function automatic bit lsb_of(input int b);
        return (b == 4);
    endfunction

    // Bit-serial reference: one message bit per step, data into the LSB.
    function automatic logic [7:0] model_fold(input logic [7:0] w, input logic [7:0] d, input bit lsb);
        logic [7:0] r;
        logic       fb;
        logic       bitv;
        r = w;
        for (int i = 0; i < 8; i++) begin
            bitv = lsb ? d[i] : d[7-i];
            fb   = r[7];
            r    = {r[6:0], bitv};
            if (fb) r = r ^ 8'h85;
        end
        return r;
    endfunction

    // Stimulus bookkeeping: advance the model, queue the result on last byte.
    task automatic note_hs(input int b, input logic [7:0] d, input bit last, input logic [7:0] e);
        mwin = model_fold(mwin, d, lsb_of(b));
        if (last) begin
            sb_crc.push_back(mwin);
            sb_match.push_back(mwin == e);
            mwin = cur_seed;
        end
    endtask

    // All stimulus tasks start and end at posedge+1.
    task automatic do_seed(input logic [7:0] v);
        seed_load  = 1'b1;
        seed_value = v;
        @(posedge clk); #1;
        seed_load = 1'b0;
        cur_seed  = v;
        mwin      = v;
        sb_crc.delete();
        sb_match.delete();
    endtask

    task automatic send_byte(input int b, input logic [7:0] d, input bit last, input logic [7:0] e, input int gap);
        bit r;
        bit done;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid_v[b] = 1'b1;
        in_data       = d;
        in_last       = last;
        expect_crc    = e;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            r = in_ready_v[b];
            @(posedge clk); #1;
            if (r) done = 1'b1;
        end
        in_valid_v[b] = 1'b0;
        in_data       = 'x;
        in_last       = 'x;
        expect_crc    = 'x;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL handshake_timeout: inst %0d byte %h not accepted in 200 cycles", b, d);
        end else begin
            last_hs_cyc = cyc;
            note_hs(b, d, last, e);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int b = 0; b < NI; b++) begin
            n_checks++; if (crc_v[b] !== 8'h00) begin n_fail++; $display("FAIL reset_crc: inst %0d got %h want 00", b, crc_v[b]); end
            n_checks++; if (match_v[b] !== 1'b0) begin n_fail++; $display("FAIL reset_match: inst %0d got %b want 0", b, match_v[b]); end
            n_checks++; if (crc_valid_v[b] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: inst %0d got %b want 0", b, crc_valid_v[b]); end
            n_checks++; if (busy_v[b] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: inst %0d got %b want 0", b, busy_v[b]); end
            n_checks++; if (in_ready_v[b] !== 1'b1) begin n_fail++; $display("FAIL reset_ready: inst %0d got %b want 1", b, in_ready_v[b]); end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Single byte 0x80 from seed 0: CRC 0x80, strobe in cycle t+9.
    task automatic test_single_byte();
        bit got;
        logic [7:0] ec;
        bit em;
        do_seed(8'h00);
        send_byte(0, 8'h80, 1'b1, 8'h80, 0);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = crc_valid_v[0]; end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL single_valid: no crc_valid within 40 cycles, want one");
        end else begin
            n_checks++; if (cyc - last_hs_cyc !== 8) begin n_fail++; $display("FAIL single_latency: got %0d edges want 8", cyc - last_hs_cyc); end
            n_checks++; if (crc_v[0] !== 8'h80) begin n_fail++; $display("FAIL single_crc: got %h want 80", crc_v[0]); end
            ec = sb_crc.pop_front(); em = sb_match.pop_front();
            n_checks++; if (crc_v[0] !== ec) begin n_fail++; $display("FAIL single_sb_crc: got %h want %h", crc_v[0], ec); end
            n_checks++; if (match_v[0] !== em) begin n_fail++; $display("FAIL single_match: got %b want %b", match_v[0], em); end
        end
        @(negedge clk);
        n_checks++; if (crc_valid_v[0] !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b want 0", crc_valid_v[0]); end
        @(posedge clk); #1;
    endtask

    // {0x80,0x00} from seed 0 in every build. By hand from the bit-step
    // recurrence, 0x80 folds 0x00->0x80 and 0x00 then folds 0x80->0x89.
    task automatic test_two_byte();
        bit got;
        logic [7:0] ec;
        logic [7:0] e;
        bit em;
        for (int b = 0; b < NI; b++) begin
            do_seed(8'h00);
            send_byte(b, 8'h80, 1'b0, 8'h00, 0);
            e = model_fold(mwin, 8'h00, lsb_of(b));
            send_byte(b, 8'h00, 1'b1, e, 1);
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = crc_valid_v[b]; end
            n_checks++;
            if (!got || sb_crc.size() == 0) begin
                n_fail++; $display("FAIL two_valid: inst %0d no crc_valid or no expected entry", b);
            end else begin
                ec = sb_crc.pop_front(); em = sb_match.pop_front();
                n_checks++; if (crc_v[b] !== ec) begin n_fail++; $display("FAIL two_crc: inst %0d got %h want %h", b, crc_v[b], ec); end
                n_checks++; if (match_v[b] !== em) begin n_fail++; $display("FAIL two_match: inst %0d got %b want %b", b, match_v[b], em); end
                n_checks++; if (cyc - last_hs_cyc !== 8 / bpc_of(b)) begin n_fail++; $display("FAIL two_latency: inst %0d got %0d want %0d", b, cyc - last_hs_cyc, 8 / bpc_of(b)); end
                if (!lsb_of(b)) begin
                    n_checks++; if (crc_v[b] !== 8'h89) begin n_fail++; $display("FAIL two_crc_const: inst %0d got %h want 89", b, crc_v[b]); end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // BPC=8, four bytes with in_valid held: ready stays high, one strobe.
    task automatic test_back_to_back();
        logic [7:0] d;
        logic [7:0] e;
        logic [7:0] ec;
        bit em;
        bit r;
        bit got;
        int p0;
        do_seed(8'h00);
        p0 = pulses[3];
        for (int i = 0; i < 4; i++) begin
            d = 8'(i * 37 + 11);
            e = (i == 3) ? model_fold(mwin, d, 1'b0) : 8'h00;
            in_valid_v[3] = 1'b1; in_data = d; in_last = (i == 3); expect_crc = e;
            @(negedge clk);
            r = in_ready_v[3];
            n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: byte %0d got %b want 1", i, r); end
            @(posedge clk); #1;
            if (r) begin last_hs_cyc = cyc; note_hs(3, d, (i == 3), e); end
        end
        in_valid_v[3] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin @(negedge clk); got = crc_valid_v[3]; end
        n_checks++;
        if (!got || sb_crc.size() == 0) begin
            n_fail++; $display("FAIL b2b_valid: no crc_valid or no expected entry");
        end else begin
            n_checks++; if (cyc - last_hs_cyc !== 1) begin n_fail++; $display("FAIL b2b_latency: got %0d edges want 1", cyc - last_hs_cyc); end
            ec = sb_crc.pop_front(); em = sb_match.pop_front();
            n_checks++; if (crc_v[3] !== ec) begin n_fail++; $display("FAIL b2b_crc: got %h want %h", crc_v[3], ec); end
            n_checks++; if (match_v[3] !== em) begin n_fail++; $display("FAIL b2b_match: got %b want %b", match_v[3], em); end
        end
        repeat (6) @(posedge clk); #1;
        n_checks++; if (pulses[3] - p0 !== 1) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d want 1", pulses[3] - p0); end
    endtask

    // Abort after the first byte of a message, reseed to 0xA5, send 0x00 last.
    // From 0xA5, eight zero bits give 0xD4.
    task automatic test_seed_abort();
        bit got;
        int p0;
        logic [7:0] e;
        logic [7:0] ec;
        bit em;
        do_seed(8'h00);
        p0 = pulses[1];
        send_byte(1, 8'h3C, 1'b0, 8'h00, 0);
        @(posedge clk); #1;
        do_seed(8'hA5);
        e = model_fold(mwin, 8'h00, 1'b0);
        send_byte(1, 8'h00, 1'b1, e, 0);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = crc_valid_v[1]; end
        n_checks++;
        if (!got || sb_crc.size() == 0) begin
            n_fail++; $display("FAIL abort_valid: no crc_valid or no expected entry");
        end else begin
            ec = sb_crc.pop_front(); em = sb_match.pop_front();
            n_checks++; if (crc_v[1] !== ec) begin n_fail++; $display("FAIL abort_crc: got %h want %h", crc_v[1], ec); end
            n_checks++; if (crc_v[1] !== 8'hD4) begin n_fail++; $display("FAIL abort_crc_const: got %h want d4", crc_v[1]); end
            n_checks++; if (match_v[1] !== em) begin n_fail++; $display("FAIL abort_match: got %b want %b", match_v[1], em); end
        end
        repeat (12) @(posedge clk); #1;
        n_checks++; if (pulses[1] - p0 !== 1) begin n_fail++; $display("FAIL abort_pulse_count: got %0d want 1", pulses[1] - p0); end
    endtask

    // Wrong reference gives crc_match=0; then reset in the middle of a byte.
    task automatic test_mismatch_reset();
        bit got;
        logic [7:0] ec;
        bit em;
        do_seed(8'h00);
        send_byte(2, 8'h80, 1'b0, 8'h00, 0);
        send_byte(2, 8'h00, 1'b1, 8'h0E, 0);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin @(negedge clk); got = crc_valid_v[2]; end
        n_checks++;
        if (!got || sb_crc.size() == 0) begin
            n_fail++; $display("FAIL mism_valid: no crc_valid or no expected entry");
        end else begin
            ec = sb_crc.pop_front(); em = sb_match.pop_front();
            n_checks++; if (crc_v[2] !== 8'h89) begin n_fail++; $display("FAIL mism_crc: got %h want 89", crc_v[2]); end
            n_checks++; if (crc_v[2] !== ec) begin n_fail++; $display("FAIL mism_sb_crc: got %h want %h", crc_v[2], ec); end
            n_checks++; if (match_v[2] !== 1'b0 || em !== 1'b0) begin n_fail++; $display("FAIL mism_match: got %b want 0", match_v[2]); end
        end
        @(posedge clk); #1;
        send_byte(2, 8'h55, 1'b0, 8'h00, 0);
        reset_n = 1'b0;
        #1;
        n_checks++; if (crc_v[2] !== 8'h00) begin n_fail++; $display("FAIL rst_crc: got %h want 00", crc_v[2]); end
        n_checks++; if (match_v[2] !== 1'b0) begin n_fail++; $display("FAIL rst_match: got %b want 0", match_v[2]); end
        n_checks++; if (crc_valid_v[2] !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", crc_valid_v[2]); end
        n_checks++; if (busy_v[2] !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_v[2]); end
        @(posedge clk); #1;
        reset_n  = 1'b1;
        cur_seed = 8'h00;
        mwin     = 8'h00;
        sb_crc.delete();
        sb_match.delete();
        @(negedge clk);
        n_checks++; if (in_ready_v[2] !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", in_ready_v[2]); end
        @(posedge clk); #1;
    endtask

    // Random messages, random gaps, random seeds, every build.
    task automatic test_random();
        localparam int NMSG = 6;
        for (int b = 0; b < NI; b++) begin
            do_seed(8'($urandom));
            fork
                begin
                    int len;
                    logic [7:0] d;
                    logic [7:0] e;
                    bit lst;
                    for (int m = 0; m < NMSG; m++) begin
                        len = $urandom_range(1, 64);
                        for (int i = 0; i < len; i++) begin
                            d   = 8'($urandom);
                            lst = (i == len - 1);
                            e   = 8'($urandom);
                            if (lst && ($urandom_range(0, 1) == 1)) e = model_fold(mwin, d, lsb_of(b));
                            send_byte(b, d, lst, e, $urandom_range(0, 3));
                        end
                    end
                end
                begin
                    bit got;
                    logic [7:0] ec;
                    bit em;
                    for (int m = 0; m < NMSG; m++) begin
                        got = 1'b0;
                        for (int n = 0; n < 2000 && !got; n++) begin @(negedge clk); got = crc_valid_v[b]; end
                        n_checks++;
                        if (!got || sb_crc.size() == 0) begin
                            n_fail++; $display("FAIL rand_valid: inst %0d msg %0d no crc_valid or no expected entry", b, m);
                        end else begin
                            ec = sb_crc.pop_front(); em = sb_match.pop_front();
                            n_checks++; if (crc_v[b] !== ec) begin n_fail++; $display("FAIL rand_crc: inst %0d msg %0d got %h want %h", b, m, crc_v[b], ec); end
                            n_checks++; if (match_v[b] !== em) begin n_fail++; $display("FAIL rand_match: inst %0d msg %0d got %b want %b", b, m, match_v[b], em); end
                        end
                    end
                end
            join
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_two_byte();
        test_back_to_back();
        test_seed_abort();
        test_mismatch_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_crc_stream_engine
`default_nettype wire
